// File: rtl/sort_11_unload.sv
// rtl/sort_11_unload.sv - captures an 11-word sorted vector and serializes it onto a word stream
// Optional feature macro: SORT_UNLOAD_DESCEND_EN (largest-first emission).
module sort_11_unload #(
    parameter int W     = 32,
    parameter int N     = 11,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data_0,
    input  logic [W-1:0]     in_data_1,
    input  logic [W-1:0]     in_data_2,
    input  logic [W-1:0]     in_data_3,
    input  logic [W-1:0]     in_data_4,
    input  logic [W-1:0]     in_data_5,
    input  logic [W-1:0]     in_data_6,
    input  logic [W-1:0]     in_data_7,
    input  logic [W-1:0]     in_data_8,
    input  logic [W-1:0]     in_data_9,
    input  logic [W-1:0]     in_data_10,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [3:0]       out_index,
    output logic             out_last,
    output logic             order_err,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [3:0] LAST_IDX = 4'(N - 1);
`ifdef SORT_UNLOAD_DESCEND_EN
    localparam logic [3:0] START_IDX = LAST_IDX;
    localparam logic [3:0] END_IDX   = 4'd0;
`else
    localparam logic [3:0] START_IDX = 4'd0;
    localparam logic [3:0] END_IDX   = LAST_IDX;
`endif

    state_t           state_q, state_d;
    logic [3:0]       ptr_q, ptr_d;
    logic [W-1:0]     data_buf_q [N];
    logic [W-1:0]     data_buf_d [N];
    logic             order_err_q, order_err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic [W-1:0]     in_vec [N];
    logic             order_bad;

    always_comb begin
        in_vec[0]  = in_data_0;
        in_vec[1]  = in_data_1;
        in_vec[2]  = in_data_2;
        in_vec[3]  = in_data_3;
        in_vec[4]  = in_data_4;
        in_vec[5]  = in_data_5;
        in_vec[6]  = in_data_6;
        in_vec[7]  = in_data_7;
        in_vec[8]  = in_data_8;
        in_vec[9]  = in_data_9;
        in_vec[10] = in_data_10;
    end

    // Equal neighbours are legal; only a strict decrease counts as a violation.
    always_comb begin
        order_bad = 1'b0;
        for (int k = 0; k < N - 1; k++) begin
            if (in_vec[k] > in_vec[k+1]) begin
                order_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_buf_d  = data_buf_q;
        order_err_d = order_err_q;
        err_count_d = err_count_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_index   = 4'd0;
        out_last    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_buf_d  = in_vec;
                    order_err_d = order_bad;
                    if (order_bad && (err_count_q != '1)) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                    ptr_d   = START_IDX;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = data_buf_q[ptr_q];
                out_index = ptr_q;
                out_last  = (ptr_q == END_IDX);
                if (out_ready) begin
                    if (ptr_q == END_IDX) begin
                        state_d = IDLE;
                    end else begin
`ifdef SORT_UNLOAD_DESCEND_EN
                        ptr_d = ptr_q - 4'd1;
`else
                        ptr_d = ptr_q + 4'd1;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 4'd0;
            order_err_q <= 1'b0;
            err_count_q <= '0;
            for (int k = 0; k < N; k++) begin
                data_buf_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            order_err_q <= order_err_d;
            err_count_q <= err_count_d;
            data_buf_q  <= data_buf_d;
        end
    end

    assign order_err = order_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_sort_11_unload.sv
// tb/tb_sort_11_unload.sv - directed self-checking bench for sort_11_unload
module tb_sort_11_unload;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] vin [11];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        order_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_11_unload dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_0(vin[0]), .in_data_1(vin[1]), .in_data_2(vin[2]), .in_data_3(vin[3]),
        .in_data_4(vin[4]), .in_data_5(vin[5]), .in_data_6(vin[6]), .in_data_7(vin[7]),
        .in_data_8(vin[8]), .in_data_9(vin[9]), .in_data_10(vin[10]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_index(out_index), .out_last(out_last), .order_err(order_err),
        .err_count(err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int emit_idx(input int i);
`ifdef SORT_UNLOAD_DESCEND_EN
        return 10 - i;
`else
        return i;
`endif
    endfunction

    task automatic load_ramp();
        for (int k = 0; k < 11; k++) vin[k] = 32'(k * 3);
    endtask

    task automatic capture();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain_check(input logic exp_err, input logic [7:0] exp_cnt);
        for (int i = 0; i < 11; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_ready", 32'(in_ready), 32'd0);
            check("drain_data", out_data, vin[emit_idx(i)]);
            check("drain_index", 32'(out_index), 32'(emit_idx(i)));
            check("drain_last", 32'(out_last), 32'(i == 10));
            check("drain_err", 32'(order_err), 32'(exp_err));
            check("drain_cnt", 32'(err_count), 32'(exp_cnt));
            tick();
        end
        check("post_idle_ready", 32'(in_ready), 32'd1);
        check("post_idle_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 11; k++) vin[k] = 32'd0;
        tick(); tick();
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_order_err", 32'(order_err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);

        // ramp vector, free-flowing output
        load_ramp();
        capture();
        drain_check(1'b0, 8'd0);

        // ramp vector, out_ready toggling: word at cycle c is (c+1)/2
        capture();
        for (int c = 0; c < 21; c++) begin
            out_ready = (c % 2 == 0);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, vin[emit_idx((c + 1) / 2)]);
            check("stall_index", 32'(out_index), 32'(emit_idx((c + 1) / 2)));
            tick();
        end
        out_ready = 1'b1;
        check("stall_end_ready", 32'(in_ready), 32'd1);
        check("stall_end_valid", 32'(out_valid), 32'd0);

        // out-of-order vector, then all-equal vector
        load_ramp();
        vin[4] = 32'd100; vin[5] = 32'd50;
        capture();
        drain_check(1'b1, 8'd1);
        check("err_hold_idle", 32'(order_err), 32'd1);
        for (int k = 0; k < 11; k++) vin[k] = 32'd7;
        capture();
        drain_check(1'b0, 8'd1);

        // in_valid held high: one capture per 12 cycles
        load_ramp();
        in_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            check("cont_in_ready", 32'(in_ready), 32'(c % 12 == 0));
            check("cont_out_valid", 32'(out_valid), 32'(c % 12 != 0));
            if (c % 12 != 0)
                check("cont_index", 32'(out_index), 32'(emit_idx(c % 12 - 1)));
            tick();
        end
        in_valid = 1'b0;
        check("cont_end_ready", 32'(in_ready), 32'd1);

        // reset after 5 handshakes
        capture();
        tick(); tick(); tick(); tick(); tick();
        check("pre_rst_index", 32'(out_index), 32'(emit_idx(5)));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cnt", 32'(err_count), 32'd0);
        check("mid_rst_err", 32'(order_err), 32'd0);
        check("mid_rst_data", out_data, 32'd0);

        // rst wins over in_valid
        rst = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        check("rst_vs_valid", 32'(out_valid), 32'd0);
        capture();
        drain_check(1'b0, 8'd0);

        // saturating error counter
        load_ramp();
        vin[4] = 32'd100; vin[5] = 32'd50;
        for (int v = 0; v < 255; v++) begin
            capture();
            for (int i = 0; i < 11; i++) tick();
        end
        check("sat_255", 32'(err_count), 32'd255);
        capture();
        check("sat_hold_err", 32'(order_err), 32'd1);
        for (int i = 0; i < 11; i++) tick();
        check("sat_no_wrap", 32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
